// File: rtl/el2_pkg.sv
// Shared PMP types, CSR address constants and core parameter bundle.
package el2_pkg;

  // Core build parameters; only the PMP entry count is used here.
  typedef struct packed {
    int unsigned PMP_ENTRIES;
  } el2_param_t;

  localparam el2_param_t EL2_PARAM_DEFAULT = '{PMP_ENTRIES: 32'd16};

  localparam int unsigned PMP_MAX_ENTRIES = 64;
  localparam int unsigned PMP_CFG_W       = 8;
  localparam int unsigned XLEN            = 32;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } el2_pmp_mode_pkt_t;

  // One pmpcfg byte, MSB first: L, reserved[1:0], A[1:0], X, W, R.
  typedef struct packed {
    logic              lock;
    logic [1:0]        reserved;
    el2_pmp_mode_pkt_t mode;
    logic              execute;
    logic              write;
    logic              read;
  } el2_pmp_cfg_pkt_t;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPCFG_LAST  = 12'h3AF;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] PMPADDR_LAST = 12'h3EF;

  // Array slots for a given entry count; a zero-entry build keeps one dead slot.
  function automatic int unsigned pmp_slots(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/el2_pmp_cfg_legal.sv
// Next-value legaliser for one pmpcfg byte: lock, reserved and R=0/W=1 rules.
module el2_pmp_cfg_legal
  import el2_pkg::*;
(
  input  el2_pmp_cfg_pkt_t old_cfg,
  input  logic             wr_en,
  input  logic [7:0]       wr_byte,
  output el2_pmp_cfg_pkt_t new_cfg
);

  el2_pmp_cfg_pkt_t wr_cfg;
  logic             keep_old;

  // Keep the old byte when not written, locked, or written with the reserved R=0/W=1 combo.
  always_comb begin
    wr_cfg   = el2_pmp_cfg_pkt_t'(wr_byte);
    keep_old = !wr_en || old_cfg.lock || (!wr_cfg.read && wr_cfg.write);
    new_cfg  = old_cfg;
    if (!keep_old) begin
      new_cfg          = wr_cfg;
      new_cfg.reserved = 2'b00;
    end
  end

endmodule

// File: rtl/el2_pmp_csr.sv
// PMP configuration/address CSR file feeding the PMP checker from registers.
module el2_pmp_csr
  import el2_pkg::*;
#(
  parameter el2_param_t pt = EL2_PARAM_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             csr_wr_en,
  input  logic [11:0]      csr_wr_addr,
  input  logic [31:0]      csr_wr_data,
  input  logic [11:0]      csr_rd_addr,
  output logic [31:0]      csr_rd_data,
  output logic             csr_rd_hit,
  output el2_pmp_cfg_pkt_t pmp_pmpcfg  [pmp_slots(pt.PMP_ENTRIES)],
  output logic [31:0]      pmp_pmpaddr [pmp_slots(pt.PMP_ENTRIES)]
);

  localparam int unsigned N_ENT   = pt.PMP_ENTRIES;
  localparam int unsigned N_SLOTS = pmp_slots(pt.PMP_ENTRIES);

  logic             wr_cfg_hit;
  logic             wr_addr_hit;
  logic [3:0]       wr_cfg_idx;
  logic [5:0]       wr_addr_idx;
  logic             rd_cfg_hit;
  logic             rd_addr_hit;
  logic [3:0]       rd_cfg_idx;
  logic [5:0]       rd_addr_idx;

  el2_pmp_cfg_pkt_t cfg_nxt [N_SLOTS];
  logic             addr_we [N_SLOTS];

  // Decode the write address into a cfg word or an address entry.
  always_comb begin
    wr_cfg_hit  = csr_wr_en && (csr_wr_addr >= PMPCFG_BASE) && (csr_wr_addr <= PMPCFG_LAST);
    wr_addr_hit = csr_wr_en && (csr_wr_addr >= PMPADDR_BASE) && (csr_wr_addr <= PMPADDR_LAST);
    wr_cfg_idx  = 4'(csr_wr_addr - PMPCFG_BASE);
    wr_addr_idx = 6'(csr_wr_addr - PMPADDR_BASE);
  end

  // Per-entry legalisation and address write-protect evaluation.
  for (genvar e = 0; e < N_SLOTS; e++) begin : g_ent
    localparam bit IMPL = (e < N_ENT);

    logic cfg_we;
    logic tor_locked;

    assign cfg_we = IMPL && wr_cfg_hit && (wr_cfg_idx == 4'(e / 4));

    el2_pmp_cfg_legal u_legal (
      .old_cfg (pmp_pmpcfg[e]),
      .wr_en   (cfg_we),
      .wr_byte (csr_wr_data[8*(e%4) +: 8]),
      .new_cfg (cfg_nxt[e])
    );

    // A locked TOR entry above freezes this entry's address, since it is its base.
    if (e + 1 < N_ENT) begin : g_next
      assign tor_locked = pmp_pmpcfg[e+1].lock && (pmp_pmpcfg[e+1].mode == PMP_TOR);
    end else begin : g_last
      assign tor_locked = 1'b0;
    end

    assign addr_we[e] = IMPL && wr_addr_hit && (wr_addr_idx == 6'(e))
                        && !pmp_pmpcfg[e].lock && !tor_locked;
  end

  // CSR register arrays; lock bits only release through reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        pmp_pmpcfg[i]  <= '0;
        pmp_pmpaddr[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        pmp_pmpcfg[i] <= cfg_nxt[i];
        if (addr_we[i]) begin
          pmp_pmpaddr[i] <= csr_wr_data;
        end
      end
    end
  end

  // Combinational read; unimplemented entries read as zero but still hit.
  always_comb begin
    rd_cfg_hit  = (csr_rd_addr >= PMPCFG_BASE) && (csr_rd_addr <= PMPCFG_LAST);
    rd_addr_hit = (csr_rd_addr >= PMPADDR_BASE) && (csr_rd_addr <= PMPADDR_LAST);
    rd_cfg_idx  = 4'(csr_rd_addr - PMPCFG_BASE);
    rd_addr_idx = 6'(csr_rd_addr - PMPADDR_BASE);
    csr_rd_hit  = rd_cfg_hit || rd_addr_hit;
    csr_rd_data = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (i < N_ENT) begin
        if (rd_cfg_hit && (rd_cfg_idx == 4'(i / 4))) begin
          csr_rd_data[8*(i%4) +: 8] = pmp_pmpcfg[i];
        end
        if (rd_addr_hit && (rd_addr_idx == 6'(i))) begin
          csr_rd_data = pmp_pmpaddr[i];
        end
      end
    end
  end

endmodule

// File: doc/el2_pmp_csr.md
# el2_pmp_csr

Holds the PMP configuration and address CSRs and drives them into the PMP checker. Implements RV32 CSR write semantics for `pmpcfg0..15` and `pmpaddr0..63`:

- per-entry lock
- TOR lock propagation to the previous entry's address
- WARL legalisation
- read-zero behaviour for unimplemented entries

Sits between the decode/CSR write path and `el2_pmp`, whose `pmp_pmpcfg`/`pmp_pmpaddr` inputs it feeds directly from registers.

## Interface
Parameters:
- `pt`, from `el2_param.vh`: uses `pt.PMP_ENTRIES` (legal values 0, 16 or 64; must be a multiple of 4).

Ports:
- `clk`  in  1  core clock.
- `rst_l`  in  1  reset. One clock; reset is asynchronous and active-low.
- `csr_wr_en`  in  1  write strobe, single-cycle.
- `csr_wr_addr`  in  12  CSR address of the write.
- `csr_wr_data`  in  32  write data.
- `csr_rd_addr`  in  12  CSR address for the combinational read.
- `csr_rd_data`  out  32  read data.
- `csr_rd_hit`  out  1  `csr_rd_addr` lies in 0x3A0–0x3EF.
- `pmp_pmpcfg`  out  `el2_pmp_cfg_pkt_t [pt.PMP_ENTRIES]`  registered configuration.
- `pmp_pmpaddr`  out  `32 x [pt.PMP_ENTRIES]`  registered addresses.

## Operation
- Address map:
  - `pmpcfgN` at 0x3A0+N covers entries 4N..4N+3. Byte k maps to entry 4N+k: lock[7], reserved[6:5], mode[4:3], X[2], W[1], R[0].
  - `pmpaddrN` at 0x3B0+N covers entry N.
- Unimplemented entries (index ≥ `PMP_ENTRIES`):
  - Writes are ignored.
  - Reads return 0.
  - `csr_rd_hit` is still 1 for any address in 0x3A0–0x3EF.
- Write legalisation is applied per cfg byte, independently:
  - Byte is ignored if the entry's current lock=1.
  - Reserved bits are stored as 0.
  - If written R=0 and W=1, the whole byte is ignored and the previous value is kept.
  - Otherwise lock, mode, X, W and R are stored as written.
- Address write to entry i is ignored if either:
  - `cfg[i].lock`=1, or
  - i+1 < `PMP_ENTRIES` and `cfg[i+1].lock`=1 and `cfg[i+1].mode`=TOR.
  - The test uses the current registered values, not the values being written.
- Lock is sticky: it clears only on reset. Nothing in this block clears it.
- Read returns the registered value: a cfg word is the concatenation of its 4 entry bytes, an addr word is the entry address.
- Writes outside 0x3A0–0x3EF are ignored.

## Timing
- Reset: every `pmp_pmpcfg` entry is 0 (OFF, unlocked), every `pmp_pmpaddr` entry is 0, and `csr_rd_data` is 0.
- A write is visible on `pmp_*` outputs and on the read port one cycle after `csr_wr_en` is sampled high.
- Reads are combinational from the registers. Read-during-write to the same CSR returns the old value.
- A single write that sets lock=1 and mode=TOR on entry i+1:
  - Protects `addr[i]` from the next cycle onward.
  - Does not affect a write in the same cycle, since only one write can occur per cycle.
- Reset asserted mid-operation clears all state asynchronously. Outputs return to reset values within the same cycle and lock bits are released.
- There is no back-pressure: every write completes in one cycle.

## Structure
- `el2_pkg` supplies `el2_pmp_cfg_pkt_t`, `el2_pmp_mode_pkt_t` and CSR base constants (`PMPCFG_BASE`=0x3A0, `PMPADDR_BASE`=0x3B0). Add these constants there if they are absent.
- One sub-module, `el2_pmp_cfg_legal`: a combinational helper that takes the old byte and the write byte and returns the next byte, applying the lock, reserved and R/W rules. It is instantiated once per entry byte.
- The register arrays live in this module, reset to zero on `negedge rst_l`.

## Test plan
- **Reset values:** assert `rst_l`=0 → every `pmp_pmpcfg` and `pmp_pmpaddr` entry reads 0; `csr_rd_data`=0 for 0x3A0 and 0x3B0.
- **Basic write:** write `pmpcfg0`=0x0F0E0D0C → one cycle later `cfg[0]`=0x0C, `cfg[1]`=0x0D, `cfg[2]`=0x0E, `cfg[3]`=0x0F after legalisation:
  - 0x0D has R=1, so it is stored as written.
  - 0x0E has R=0, W=1, so it is dropped and the old value 0 is kept.
- **Entry lock:** write `pmpcfg0`=0x00000089 (entry 0: lock, NAPOT... mode 01 TOR, R) → then write `pmpaddr0`=0x1234 and `pmpcfg0`=0 → `cfg[0]` stays 0x89 and `addr[0]` stays 0.
- **TOR lock propagation:** write `pmpaddr0`=0x1000, then `pmpcfg0`=0x00008900 (entry 1: lock+TOR) → a later write of `pmpaddr0`=0x2000 is ignored (`addr[0]`=0x1000), and `pmpaddr1` is also locked.
- **Unimplemented entries:** with `PMP_ENTRIES`=16, write `pmpaddr20`=0xFFFFFFFF → read 0x3C4 returns 0 with `csr_rd_hit`=1; read 0x3F0 gives `csr_rd_hit`=0.
- **Reset mid-operation:** set a lock, then pulse `rst_l`=0 asynchronously mid-cycle → outputs are 0 immediately, and a subsequent write to that entry succeeds.
